// File: rtl/spdif_subframe_assembler.sv
// spdif_subframe_assembler
// ------------------------
// Sits directly behind the S/PDIF biphase decoder. The raw line is used only
// to find preambles: the length of every run between line transitions is
// measured and classified as 1, 2 or 3 UI. The decoder's data bit and bit
// clock supply the 28 payload slots. One parallel subframe is reported per
// o_valid pulse.
//
// Ports
//   clk             system clock, shared with the decoder
//   i_rst_n         asynchronous active-low reset
//   i_spdif         raw S/PDIF line (asynchronous, synchronised here)
//   i_bit           decoded data bit
//   i_bit_clk       decoded bit clock, one rising edge per data bit
//   o_sample        audio word from slots 4..27 (slot 4 = LSB)
//   o_v, o_u, o_c   validity / user / channel-status bits (slots 28..30)
//   o_chan          0 = channel A (B or M preamble), 1 = channel B (W)
//   o_block_start   subframe began with a B preamble
//   o_valid         one-clk pulse when the outputs above update
//   o_parity_err    even parity over slots 4..31 failed (qualified by o_valid)
//   o_sync_err      one-clk pulse on a framing or line error
//   o_locked        set by a good subframe, cleared by any sync error
//
// Optional feature, macro SPDIF_CHSTAT_EN:
//   o_chstat        32 channel-status bits collected from channel A
//   o_chstat_valid  one-clk pulse when o_chstat is loaded
module spdif_subframe_assembler #(
    parameter int unsigned SHORT_MAX = 5,
    parameter int unsigned MID_MAX   = 9,
    parameter int unsigned LONG_MAX  = 14
) (
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic        i_spdif,
    input  logic        i_bit,
    input  logic        i_bit_clk,
    output logic [23:0] o_sample,
    output logic        o_v,
    output logic        o_u,
    output logic        o_c,
    output logic        o_chan,
    output logic        o_block_start,
    output logic        o_valid,
    output logic        o_parity_err,
    output logic        o_sync_err,
    output logic        o_locked
`ifdef SPDIF_CHSTAT_EN
    ,
    output logic [31:0] o_chstat,
    output logic        o_chstat_valid
`endif
);

    localparam logic [4:0] SHORT_LIM = 5'(SHORT_MAX);
    localparam logic [4:0] MID_LIM   = 5'(MID_MAX);
    localparam logic [4:0] LONG_LIM  = 5'(LONG_MAX);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        PRE1 = 2'd1,
        PRE2 = 2'd2,
        DATA = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        RUN_S   = 2'd0,
        RUN_M2  = 2'd1,
        RUN_L3  = 2'd2,
        RUN_ERR = 2'd3
    } run_t;

    typedef enum logic [1:0] {
        PRE_B = 2'd0,
        PRE_W = 2'd1,
        PRE_M = 2'd2
    } pre_t;

    // Even parity check: 1 when the covered bits hold an odd number of ones.
    function automatic logic parity_fail(input logic [27:0] data);
        return ^data;
    endfunction

    logic        line_meta_r;
    logic        line_sync_r;
    logic        line_prev_r;
    logic        trans_s;
    logic [4:0]  run_cnt_r;
    run_t        run_class_s;
    logic        bit_clk_prev_r;
    logic        strobe_s;

    state_t      state_r;
    state_t      state_n;
    pre_t        type_r;
    pre_t        type_n;
    logic        pre_idx_r;
    logic        pre_idx_n;
    run_t        exp_second_s;
    logic        sync_err_s;
    logic        fire_s;
    logic        shift_s;
    logic        fire_r;

    logic [27:0] sr_r;
    logic [4:0]  bit_cnt_r;

    // Two-flop synchroniser on the raw line plus one delay stage for edge detect.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            line_meta_r <= 1'b0;
            line_sync_r <= 1'b0;
            line_prev_r <= 1'b0;
        end else begin
            line_meta_r <= i_spdif;
            line_sync_r <= line_meta_r;
            line_prev_r <= line_sync_r;
        end
    end

    assign trans_s = line_sync_r ^ line_prev_r;

    // Run-length counter: reloads on each transition, saturates at 31.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            run_cnt_r <= 5'd0;
        end else if (trans_s) begin
            run_cnt_r <= 5'd1;
        end else if (run_cnt_r != 5'd31) begin
            run_cnt_r <= run_cnt_r + 5'd1;
        end else begin
            run_cnt_r <= run_cnt_r;
        end
    end

    // Classify the run that ends at the current transition.
    always_comb begin
        run_class_s = RUN_ERR;
        if (run_cnt_r <= SHORT_LIM) begin
            run_class_s = RUN_S;
        end else if (run_cnt_r <= MID_LIM) begin
            run_class_s = RUN_M2;
        end else if (run_cnt_r <= LONG_LIM) begin
            run_class_s = RUN_L3;
        end else begin
            run_class_s = RUN_ERR;
        end
    end

    // Bit clock edge detector.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bit_clk_prev_r <= 1'b0;
        end else begin
            bit_clk_prev_r <= i_bit_clk;
        end
    end

    assign strobe_s = i_bit_clk & ~bit_clk_prev_r;

    // Final preamble run that closes each preamble type.
    always_comb begin
        exp_second_s = RUN_S;
        case (type_r)
            PRE_B:   exp_second_s = RUN_L3;
            PRE_W:   exp_second_s = RUN_M2;
            PRE_M:   exp_second_s = RUN_S;
            default: exp_second_s = RUN_S;
        endcase
    end

    // FSM state, preamble type and preamble step registers.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r   <= HUNT;
            type_r    <= PRE_B;
            pre_idx_r <= 1'b0;
            fire_r    <= 1'b0;
        end else begin
            state_r   <= state_n;
            type_r    <= type_n;
            pre_idx_r <= pre_idx_n;
            fire_r    <= fire_s;
        end
    end

    // Next-state logic: preamble recognition, payload counting, error handling.
    always_comb begin
        state_n    = state_r;
        type_n     = type_r;
        pre_idx_n  = pre_idx_r;
        sync_err_s = 1'b0;
        fire_s     = 1'b0;
        shift_s    = 1'b0;
        case (state_r)
            HUNT: begin
                if (trans_s && (run_class_s == RUN_L3)) begin
                    state_n = PRE1;
                end else begin
                    state_n = HUNT;
                end
            end
            PRE1: begin
                pre_idx_n = 1'b0;
                if (trans_s) begin
                    case (run_class_s)
                        RUN_S:   begin type_n = PRE_B; state_n = PRE2; end
                        RUN_M2:  begin type_n = PRE_W; state_n = PRE2; end
                        RUN_L3:  begin type_n = PRE_M; state_n = PRE2; end
                        default: state_n = HUNT;
                    endcase
                end else begin
                    state_n = PRE1;
                end
            end
            PRE2: begin
                if (!trans_s) begin
                    state_n = PRE2;
                end else if (!pre_idx_r) begin
                    // Every preamble continues with one short run.
                    if (run_class_s == RUN_S) begin
                        pre_idx_n = 1'b1;
                    end else begin
                        sync_err_s = 1'b1;
                        state_n    = HUNT;
                    end
                end else if (run_class_s == exp_second_s) begin
                    state_n = DATA;
                end else begin
                    sync_err_s = 1'b1;
                    state_n    = HUNT;
                end
            end
            DATA: begin
                if (trans_s && (run_class_s == RUN_L3)) begin
                    // A 3-UI run can only be a preamble: the word is cut short
                    // and this run starts the next preamble.
                    sync_err_s = 1'b1;
                    state_n    = PRE1;
                end else if (strobe_s) begin
                    shift_s = 1'b1;
                    if (bit_cnt_r == 5'd27) begin
                        fire_s  = 1'b1;
                        state_n = HUNT;
                    end else begin
                        state_n = DATA;
                    end
                end else begin
                    state_n = DATA;
                end
            end
            default: state_n = HUNT;
        endcase
        // A run too long for any symbol is a line fault in every state.
        if (trans_s && (run_class_s == RUN_ERR)) begin
            sync_err_s = 1'b1;
            fire_s     = 1'b0;
            state_n    = HUNT;
        end else begin
            sync_err_s = sync_err_s;
        end
    end

    // Payload shift register (LSB first into the MSB) and slot counter;
    // both stay cleared whenever the FSM is outside DATA.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sr_r      <= 28'd0;
            bit_cnt_r <= 5'd0;
        end else if (state_r != DATA) begin
            sr_r      <= 28'd0;
            bit_cnt_r <= 5'd0;
        end else if (shift_s) begin
            sr_r      <= {i_bit, sr_r[27:1]};
            bit_cnt_r <= bit_cnt_r + 5'd1;
        end else begin
            sr_r      <= sr_r;
            bit_cnt_r <= bit_cnt_r;
        end
    end

    // Output registers: loaded the cycle after the last payload strobe.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_sample      <= 24'd0;
            o_v           <= 1'b0;
            o_u           <= 1'b0;
            o_c           <= 1'b0;
            o_chan        <= 1'b0;
            o_block_start <= 1'b0;
            o_parity_err  <= 1'b0;
            o_valid       <= 1'b0;
            o_sync_err    <= 1'b0;
            o_locked      <= 1'b0;
        end else begin
            o_valid    <= fire_r;
            o_sync_err <= sync_err_s;
            if (fire_r) begin
                o_sample      <= sr_r[23:0];
                o_v           <= sr_r[24];
                o_u           <= sr_r[25];
                o_c           <= sr_r[26];
                o_chan        <= (type_r == PRE_W);
                o_block_start <= (type_r == PRE_B);
                o_parity_err  <= parity_fail(sr_r);
            end
            if (sync_err_s) begin
                o_locked <= 1'b0;
            end else if (fire_r) begin
                o_locked <= 1'b1;
            end
        end
    end

`ifdef SPDIF_CHSTAT_EN
    logic [31:0] chstat_coll_r;
    logic [4:0]  chstat_idx_r;
    logic        chstat_active_r;

    // Channel-status collector: gathers the C bit of 32 channel-A subframes,
    // starting at a B preamble; any sync error abandons the block.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            chstat_coll_r   <= 32'd0;
            chstat_idx_r    <= 5'd0;
            chstat_active_r <= 1'b0;
            o_chstat        <= 32'd0;
            o_chstat_valid  <= 1'b0;
        end else begin
            o_chstat_valid <= 1'b0;
            if (sync_err_s) begin
                chstat_active_r <= 1'b0;
            end else if (fire_r && (type_r == PRE_B)) begin
                chstat_coll_r   <= {31'd0, sr_r[26]};
                chstat_idx_r    <= 5'd1;
                chstat_active_r <= 1'b1;
            end else if (fire_r && (type_r == PRE_M) && chstat_active_r) begin
                chstat_coll_r[chstat_idx_r] <= sr_r[26];
                chstat_idx_r                <= chstat_idx_r + 5'd1;
                if (chstat_idx_r == 5'd31) begin
                    o_chstat        <= {sr_r[26], chstat_coll_r[30:0]};
                    o_chstat_valid  <= 1'b1;
                    chstat_active_r <= 1'b0;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_spdif_subframe_assembler.sv
// Directed bench for spdif_subframe_assembler. The line is driven as a
// biphase stream (4 clk per UI); preamble run orders are B = L3,S,S,L3,
// W = L3,M2,S,M2, M = L3,L3,S,S. The decoded bit and bit clock are driven
// alongside each data cell.
module tb_spdif_subframe_assembler;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic        i_spdif;
    logic        i_bit;
    logic        i_bit_clk;
    logic [23:0] o_sample;
    logic        o_v, o_u, o_c, o_chan, o_block_start;
    logic        o_valid, o_parity_err, o_sync_err, o_locked;
`ifdef SPDIF_CHSTAT_EN
    logic [31:0] o_chstat;
    logic        o_chstat_valid;
    int          chv_cnt = 0;
`endif

    always #5 clk = ~clk;

    spdif_subframe_assembler dut (
        .clk           (clk),
        .i_rst_n       (i_rst_n),
        .i_spdif       (i_spdif),
        .i_bit         (i_bit),
        .i_bit_clk     (i_bit_clk),
        .o_sample      (o_sample),
        .o_v           (o_v),
        .o_u           (o_u),
        .o_c           (o_c),
        .o_chan        (o_chan),
        .o_block_start (o_block_start),
        .o_valid       (o_valid),
        .o_parity_err  (o_parity_err),
        .o_sync_err    (o_sync_err),
        .o_locked      (o_locked)
`ifdef SPDIF_CHSTAT_EN
        ,
        .o_chstat      (o_chstat),
        .o_chstat_valid(o_chstat_valid)
`endif
    );

    typedef struct {
        logic [1:0]  pre;       // 0 = B, 1 = W, 2 = M
        logic [23:0] sample;
        logic        v, u, c, p;
        logic        exp_chan, exp_block, exp_perr;
    } vec_t;

    vec_t vecs[6];
    int   n_cmp = 0;
    int   n_err = 0;
    int   valid_cnt = 0;
    int   serr_cnt = 0;
    logic lock_at_err = 1'b1;

    // Pulse monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (o_valid) valid_cnt++;
        if (o_sync_err) begin
            serr_cnt++;
            lock_at_err = o_locked;
        end
`ifdef SPDIF_CHSTAT_EN
        if (o_chstat_valid) chv_cnt++;
`endif
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_run(input int len);
        i_spdif = ~i_spdif;
        repeat (len) tick();
    endtask

    task automatic send_pre(input logic [1:0] kind);
        send_run(12);
        case (kind)
            2'd0:    begin send_run(4);  send_run(4); send_run(12); end
            2'd1:    begin send_run(8);  send_run(4); send_run(8);  end
            default: begin send_run(12); send_run(4); send_run(4);  end
        endcase
    endtask

    // One 8-clk biphase cell; the bit clock rises mid-cell.
    task automatic send_bit(input logic b);
        i_bit = b;
        for (int k = 0; k < 8; k++) begin
            if (k == 0 || (k == 4 && b)) i_spdif = ~i_spdif;
            i_bit_clk = (k == 5 || k == 6);
            tick();
        end
    endtask

    task automatic send_sub(input logic [1:0] kind, input logic [27:0] w, input int nbits);
        send_pre(kind);
        for (int i = 0; i < nbits; i++) send_bit(w[i]);
    endtask

    function automatic logic [27:0] word_of(input vec_t v);
        return {v.p, v.c, v.u, v.v, v.sample};
    endfunction

    task automatic send_and_check(input vec_t v, input string tag, input int exp_serr);
        int v0, s0;
        v0 = valid_cnt;
        s0 = serr_cnt;
        send_sub(v.pre, word_of(v), 28);
        check({tag, ".valid_pulses"}, 32'(valid_cnt - v0), 32'd1);
        check({tag, ".sync_errs"},    32'(serr_cnt - s0),  32'(exp_serr));
        check({tag, ".sample"},       32'(o_sample),       32'(v.sample));
        check({tag, ".v"},            32'(o_v),            32'(v.v));
        check({tag, ".u"},            32'(o_u),            32'(v.u));
        check({tag, ".c"},            32'(o_c),            32'(v.c));
        check({tag, ".chan"},         32'(o_chan),         32'(v.exp_chan));
        check({tag, ".block_start"},  32'(o_block_start),  32'(v.exp_block));
        check({tag, ".parity_err"},   32'(o_parity_err),   32'(v.exp_perr));
        check({tag, ".locked"},       32'(o_locked),       32'd1);
    endtask

    initial begin
        int v0, s0;
        logic [27:0] w;
        // Parity bits and expected flags worked out by hand:
        // 0x123456 has 9 ones, +U+C = 11, so P=1 gives even parity.
        vecs[0] = '{2'd0, 24'h123456, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        // 0xFFFFFF has 24 ones; P=1 is wrong.
        vecs[1] = '{2'd1, 24'hFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        // V alone is one; P=1 correct.
        vecs[2] = '{2'd2, 24'h000000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        // 12 ones +C = 13; P=0 is wrong.
        vecs[3] = '{2'd2, 24'hA5A5A5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        // 2 ones +V+U = 4; P=0 correct.
        vecs[4] = '{2'd0, 24'h800001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        // 22 ones +U+C = 24; P=0 correct.
        vecs[5] = '{2'd1, 24'h7FFFFE, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

        i_rst_n = 1'b0; i_spdif = 1'b0; i_bit = 1'b0; i_bit_clk = 1'b0;
        repeat (4) tick();
        check("reset.valid",  32'(o_valid),    32'd0);
        check("reset.serr",   32'(o_sync_err), 32'd0);
        check("reset.locked", 32'(o_locked),   32'd0);
        check("reset.sample", 32'(o_sample),   32'd0);
        i_rst_n = 1'b1;
        repeat (3) tick();

        // Idle short runs; the first one ends a saturated run (line error).
        for (int i = 0; i < 4; i++) send_run(4);
        check("prelude.locked", 32'(o_locked), 32'd0);

        for (int i = 0; i < 6; i++) send_and_check(vecs[i], $sformatf("vec%0d", i), 0);

        // Premature M preamble after 20 data bits.
        v0 = valid_cnt;
        s0 = serr_cnt;
        send_sub(2'd0, word_of(vecs[0]), 20);
        send_and_check(vecs[2], "premature", 1);
        check("premature.valid_total", 32'(valid_cnt - v0), 32'd1);
        check("premature.lock_at_err", 32'(lock_at_err),    32'd0);

        // Line held for 40 clk mid-subframe, then recovery on a W subframe.
        v0 = valid_cnt;
        send_sub(2'd0, word_of(vecs[0]), 10);
        repeat (40) tick();
        check("hold.no_valid", 32'(valid_cnt - v0), 32'd0);
        send_and_check(vecs[1], "hold_recover", 1);
        check("hold.lock_at_err", 32'(lock_at_err), 32'd0);

        // Asynchronous reset at bit 15 of a subframe.
        v0 = valid_cnt;
        send_sub(2'd0, word_of(vecs[4]), 15);
        #3 i_rst_n = 1'b0;
        #1;
        check("midrst.sample", 32'(o_sample),      32'd0);
        check("midrst.chan",   32'(o_chan),        32'd0);
        check("midrst.perr",   32'(o_parity_err),  32'd0);
        check("midrst.locked", 32'(o_locked),      32'd0);
        check("midrst.flags",  32'({o_v, o_u, o_c, o_block_start, o_valid, o_sync_err}), 32'd0);
        repeat (3) tick();
        i_rst_n = 1'b1;
        w = word_of(vecs[4]);
        for (int i = 15; i < 28; i++) send_bit(w[i]);
        check("midrst.no_valid", 32'(valid_cnt - v0), 32'd0);
        send_sub(vecs[5].pre, word_of(vecs[5]), 28);
        check("midrst.valid_after", 32'(valid_cnt - v0), 32'd1);
        check("midrst.sample_after", 32'(o_sample), 32'h7FFFFE);

`ifdef SPDIF_CHSTAT_EN
        begin
            logic [31:0] cbits;
            int c0;
            cbits = 32'hA5A50F0F;
            c0 = chv_cnt;
            for (int i = 0; i < 32; i++) begin
                w = {1'b0, cbits[i], 2'b00, 24'(i)};
                send_sub((i == 0) ? 2'd0 : 2'd2, w, 28);
            end
            check("chstat.pulses", 32'(chv_cnt - c0), 32'd1);
            check("chstat.value",  o_chstat,          32'hA5A50F0F);
        end
`endif

        repeat (4) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
